// File: rtl/mole_generator.sv
// Purpose: picks the whack-a-mole hole and holds it for a dwell that shrinks on every correct hit.
// Latency: enable-from-idle and hit both relocate at the sampling edge; pos/strobe valid the next cycle.
// Backpressure: none; hit is a fire-and-forget pulse, ignored while idle.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       level-sensitive game run
//   hit          one-cycle correct-whack pulse
//   mole_pos     registered current hole, 0..NUM_HOLES-1
//   mole_change  one-cycle strobe in the first cycle a new mole_pos is valid
//   level        hits taken, saturating at 15
module mole_generator #(
  parameter int unsigned NUM_HOLES   = 5,
  parameter int unsigned PERIOD_INIT = 100_000_000,
  parameter int unsigned PERIOD_MIN  = 25_000_000,
  parameter int unsigned PERIOD_STEP = 5_000_000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       hit,
  output logic [2:0] mole_pos,
  output logic       mole_change,
  output logic [3:0] level
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_SHOW = 1'b1;

  localparam logic [3:0]  HOLES  = 4'(NUM_HOLES);
  localparam logic [31:0] P_INIT = 32'(PERIOD_INIT);
  localparam logic [31:0] P_MIN  = 32'(PERIOD_MIN);
  localparam logic [31:0] P_STEP = 32'(PERIOD_STEP);

  logic [0:0]  state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [2:0]  mole_pos_q, mole_pos_d;
  logic        mole_change_q, mole_change_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] period_q, period_d;
  logic [31:0] timer_q, timer_d;

  // Candidate hole from the low LFSR bits, folded into range and then
  // bumped past the current hole so a relocation always moves the mole.
  logic [3:0]  cand_raw;
  logic [3:0]  cand_wrap;
  logic [3:0]  pos_inc;
  logic [2:0]  pick;

  always_comb begin
    cand_raw  = {1'b0, lfsr_q[2:0]};
    cand_wrap = (cand_raw >= HOLES) ? (cand_raw - HOLES) : cand_raw;
    pos_inc   = {1'b0, mole_pos_q} + 4'd1;
    if (cand_wrap == {1'b0, mole_pos_q}) begin
      pick = (pos_inc == HOLES) ? 3'd0 : pos_inc[2:0];
    end else begin
      pick = cand_wrap[2:0];
    end
  end

  logic        relocate;
  logic [31:0] reload_period;

  always_comb begin
    state_d       = state_q;
    // x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3, shifting towards the MSB.
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    mole_pos_d    = mole_pos_q;
    mole_change_d = 1'b0;
    level_d       = level_q;
    period_d      = period_q;
    timer_d       = timer_q;
    relocate      = 1'b0;
    reload_period = period_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          relocate = 1'b1;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          // A hit wins over a coincident expiry, and the shortened period
          // already governs the dwell that starts at this relocation.
          level_d       = (level_q == 4'hF) ? level_q : level_q + 4'd1;
          reload_period = (period_q <= P_MIN + P_STEP) ? P_MIN : period_q - P_STEP;
          period_d      = reload_period;
          relocate      = 1'b1;
        end else if (timer_q == 32'd0) begin
          relocate = 1'b1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (relocate) begin
      mole_pos_d    = pick;
      mole_change_d = 1'b1;
      // Counting down to zero inclusive makes pulses exactly `period` apart.
      timer_d       = reload_period - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      mole_pos_q    <= 3'd0;
      mole_change_q <= 1'b0;
      level_q       <= 4'd0;
      period_q      <= P_INIT;
      timer_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      mole_pos_q    <= mole_pos_d;
      mole_change_q <= mole_change_d;
      level_q       <= level_d;
      period_q      <= period_d;
      timer_q       <= timer_d;
    end
  end

  assign mole_pos    = mole_pos_q;
  assign mole_change = mole_change_q;
  assign level       = level_q;

endmodule

// File: tb/tb_mole_generator.sv
// Bench for mole_generator: directed game scenarios plus random enable/hit/reset traffic,
// every cycle compared against an absolute-deadline reference model.
module tb_mole_generator;

  localparam int NH    = 5;
  localparam int PINIT = 20;
  localparam int PMIN  = 8;
  localparam int PSTEP = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] mole_pos;
  logic       mole_change;
  logic [3:0] level;

  mole_generator #(
    .NUM_HOLES(NH), .PERIOD_INIT(PINIT), .PERIOD_MIN(PMIN),
    .PERIOD_STEP(PSTEP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .hit(hit),
    .mole_pos(mole_pos), .mole_change(mole_change), .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game time is an absolute edge count; a running game
  // simply knows the edge at which its current dwell ends.
  logic [7:0] m_lfsr;
  bit         m_running;
  int         m_pos, m_level, m_period, m_deadline, m_cyc;
  bit         m_change;

  function automatic int pick_hole(input logic [7:0] lf, input int cur);
    int c;
    c = int'(lf) % 8;
    if (c >= NH) c -= NH;
    if (c == cur) c = (cur + 1) % NH;
    return c;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit h);
    bit move;
    if (r) begin
      m_lfsr = SEED; m_running = 0; m_pos = 0; m_change = 0;
      m_level = 0; m_period = PINIT;
    end else begin
      move = 0;
      if (!m_running) begin
        if (e) begin move = 1; m_running = 1; end
      end else if (!e) begin
        m_running = 0;
      end else if (h) begin
        if (m_level < 15) m_level++;
        m_period = (m_period - PSTEP < PMIN) ? PMIN : m_period - PSTEP;
        move = 1;
      end else if (m_cyc == m_deadline) begin
        move = 1;
      end
      m_change = move;
      if (move) begin
        m_pos = pick_hole(m_lfsr, m_pos);
        m_deadline = m_cyc + m_period;
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit e, input bit h);
    rst = r; enable = e; hit = h;
    @(posedge clk);
    model_edge(r, e, h);
    #1;
    check("mole_pos", 32'(mole_pos), 32'(m_pos));
    check("mole_change", 32'(mole_change), 32'(m_change));
    check("level", 32'(level), 32'(m_level));
  endtask

  // Advance with enable high and no hits until a pulse; n = cycles taken
  // (exceeds the bound if no pulse arrived, which the caller's check catches).
  task automatic run_until_pulse(output int n);
    n = 0;
    do begin
      step(0, 1, 0);
      n++;
    end while (!mole_change && n <= 100);
  endtask

  int n, prev_pos, pos_hold, lvl_hold;
  bit en_r;
  int exp_int [6] = '{16, 12, 8, 8, 8, 8};

  initial begin
    m_cyc = 0; m_deadline = 0;
    // Reset and idle, with hits that must be ignored.
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("rst_pos", 32'(mole_pos), 0);
    check("rst_lvl", 32'(level), 0);
    for (int i = 0; i < 50; i++) step(0, 0, ($urandom_range(0, 3) == 0));
    check("idle_chg", 32'(mole_change), 0);
    check("idle_lvl", 32'(level), 0);

    // Free-run: immediate pulse on enable, then fixed 20-cycle dwell.
    step(0, 1, 0);
    check("en_latency", 32'(mole_change), 1);
    prev_pos = mole_pos;
    for (int k = 1; k < 200; k++) begin
      run_until_pulse(n);
      check("freerun_interval", n, PINIT);
      check("pos_range", 32'(mole_pos < NH), 1);
      check("pos_repeat", 32'(mole_pos == prev_pos), 0);
      prev_pos = mole_pos;
    end

    // Speed-up: hit 5 cycles after each expiry pulse.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 5; j++) step(0, 1, 0);
      step(0, 1, 1);
      check("hit_pulse", 32'(mole_change), 1);
      check("hit_level", 32'(level), i + 1);
      run_until_pulse(n);
      check("speedup_interval", n, exp_int[i]);
    end
    for (int i = 0; i < 14; i++) begin
      step(0, 1, 1);
      step(0, 1, 0);
    end
    check("level_sat", 32'(level), 15);
    step(0, 1, 1);
    check("level_sat_hold", 32'(level), 15);

    // Coincident hit and expiry.
    step(1, 0, 0);
    step(0, 1, 0);
    check("reen_latency", 32'(mole_change), 1);
    for (int j = 0; j < 19; j++) step(0, 1, 0);
    check("pre_coinc_chg", 32'(mole_change), 0);
    step(0, 1, 1);
    check("coinc_pulse", 32'(mole_change), 1);
    check("coinc_level", 32'(level), 1);
    step(0, 1, 0);
    check("coinc_single", 32'(mole_change), 0);
    run_until_pulse(n);
    check("coinc_interval", n + 1, 16);

    // Enable drop at cycle 7 of a dwell, with a hit while disabled.
    for (int j = 0; j < 6; j++) step(0, 1, 0);
    pos_hold = mole_pos; lvl_hold = level;
    for (int j = 0; j < 30; j++) begin
      step(0, 0, (j == 10));
      check("drop_nopulse", 32'(mole_change), 0);
    end
    check("drop_pos", 32'(mole_pos), 32'(pos_hold));
    check("drop_level", 32'(level), 32'(lvl_hold));
    step(0, 1, 0);
    check("drop_reen", 32'(mole_change), 1);
    run_until_pulse(n);
    check("drop_interval", n, 16);

    // Reset mid-game at level 3.
    step(0, 1, 1);
    step(0, 1, 1);
    check("mid_level3", 32'(level), 3);
    step(1, 0, 0);
    check("mid_rst_pos", 32'(mole_pos), 0);
    check("mid_rst_lvl", 32'(level), 0);
    check("mid_rst_chg", 32'(mole_change), 0);
    step(0, 1, 0);
    check("mid_reen", 32'(mole_change), 1);
    run_until_pulse(n);
    check("mid_interval", n, PINIT);

    // Random traffic against the model.
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = !en_r;
      step(($urandom_range(0, 999) == 0), en_r, ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
